// File: rtl/link_pkg.sv
// link_pkg: framing constants and receiver state shared by both ends of the serial link
package link_pkg;
  localparam int BYTE_W           = 8;
  localparam int LINK_SYNC_STAGES = 2;
  localparam int LINK_MIN_PERIOD  = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} link_state_t;
endpackage

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: first-word-fall-through sync FIFO; a push into a full FIFO only lands if a pop frees a slot
module link_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem   <= '{default: '0};
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/link_rx_deserializer.sv
// link_rx_deserializer: oversamples the remote link pins, assembles MSB-first bytes and queues them
// for the downstream stage; the link clock is only ever sampled as data.
module link_rx_deserializer #(
  parameter int BYTE_W      = link_pkg::BYTE_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = link_pkg::LINK_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          link_clk_in,
  input  logic                          link_data_in,
  input  logic                          link_rdy_in,
  output logic [BYTE_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic [2:0]                    bit_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);
  import link_pkg::*;
  logic [SYNC_STAGES-1:0] r_sclk;
  logic [SYNC_STAGES-1:0] r_sdat;
  logic [SYNC_STAGES-1:0] r_srdy;
  logic                   r_clk_q;
  link_state_t            r_state;
  link_state_t            w_state_n;
  logic [BYTE_W-1:0]      r_shreg;
  logic [BYTE_W-1:0]      w_shreg_n;
  logic [2:0]             r_bit_count;
  logic [2:0]             w_bit_n;
  logic                   r_frame_err;
  logic                   w_err_n;
  logic                   r_overflow;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_rdy_s;
  logic                   w_edge;
  assign w_clk_s = r_sclk[SYNC_STAGES-1];
  assign w_dat_s = r_sdat[SYNC_STAGES-1];
  assign w_rdy_s = r_srdy[SYNC_STAGES-1];
  assign w_edge  = w_clk_s & ~r_clk_q;
  // All three pins share one synchronizer depth so data stays aligned with its clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk  <= '0;
      r_sdat  <= '0;
      r_srdy  <= '0;
      r_clk_q <= 1'b0;
    end else begin
      r_sclk  <= {r_sclk[SYNC_STAGES-2:0], link_clk_in};
      r_sdat  <= {r_sdat[SYNC_STAGES-2:0], link_data_in};
      r_srdy  <= {r_srdy[SYNC_STAGES-2:0], link_rdy_in};
      r_clk_q <= w_clk_s;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_count <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_shreg     <= w_shreg_n;
      r_bit_count <= w_bit_n;
      r_frame_err <= w_err_n;
      r_overflow  <= r_overflow | w_drop;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_bit_n   = r_bit_count;
    w_err_n   = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_n   = '0;
        w_state_n = w_rdy_s ? SHIFT : IDLE;
      end
      SHIFT: begin
        if (!w_rdy_s) begin
          w_state_n = IDLE;
          w_err_n   = r_bit_count != '0;
          w_bit_n   = '0;
        end else if (w_edge) begin
          w_shreg_n = {r_shreg[BYTE_W-2:0], w_dat_s};
          w_bit_n   = r_bit_count + 3'd1;
          w_state_n = (r_bit_count == 3'(BYTE_W - 1)) ? COMMIT : SHIFT;
        end
      end
      COMMIT: begin
        w_push    = 1'b1;
        w_state_n = w_rdy_s ? SHIFT : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  link_rx_fifo #(
    .W     (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (rx_ready),
    .i_data  (r_shreg),
    .o_data  (rx_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (fifo_count),
    .o_drop  (w_drop)
  );
  assign rx_valid  = ~w_empty;
  assign rx_busy   = r_state != IDLE;
  assign bit_count = r_bit_count;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
endmodule
